// File: rtl/banked_dmem_ctrl.sv
// Banked shared data-memory controller.
// NCORES request ports are served by NBANKS word-interleaved, byte-strobed banks.
// Each bank has its own round-robin arbiter, and each core has its own LR/SC reservation.
module banked_dmem_ctrl #(
  parameter int NCORES = 4,
  parameter int NBANKS = 2,
  parameter int ADDRW  = 12,
  parameter int DATAW  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NCORES-1:0]           re_packed_i,
  input  logic [NCORES-1:0]           we_packed_i,
  input  logic [ADDRW*NCORES-1:0]     addr_packed_i,
  input  logic [DATAW*NCORES-1:0]     wdata_packed_i,
  input  logic [(DATAW/8)*NCORES-1:0] wstrb_packed_i,
  input  logic [NCORES-1:0]           is_lr_packed_i,
  input  logic [NCORES-1:0]           is_sc_packed_i,
  output logic [DATAW*NCORES-1:0]     rdata_packed_o,
  output logic [NCORES-1:0]           stall_packed_o
);

  localparam int STRBW = DATAW / 8;
  localparam int LOGNB = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BSELW = (LOGNB > 0) ? LOGNB : 1;
  localparam int ROWW  = ADDRW - LOGNB;
  localparam int ROWS  = 1 << ROWW;
  localparam int PTRW  = (NCORES > 1) ? $clog2(NCORES) : 1;

  // Unpacked per-core views of the request bus
  logic [ADDRW-1:0] w_addr  [NCORES];
  logic [DATAW-1:0] w_wdata [NCORES];
  logic [STRBW-1:0] w_wstrb [NCORES];
  logic [BSELW-1:0] w_bsel  [NCORES];
  logic [ROWW-1:0]  w_row   [NCORES];
  logic [NCORES-1:0] w_req, w_lr, w_sc, w_scOk, w_grant;

  // Per-bank arbitration results and the granted core's request fields
  logic [NBANKS-1:0] w_bankGnt, w_bankWrite;
  logic [PTRW-1:0]   w_bankCore  [NBANKS];
  logic [ROWW-1:0]   w_bankRow   [NBANKS];
  logic [ADDRW-1:0]  w_bankAddr  [NBANKS];
  logic [DATAW-1:0]  w_bankWdata [NBANKS];
  logic [STRBW-1:0]  w_bankWstrb [NBANKS];
  logic [DATAW-1:0]  w_bankRdata [NBANKS];

  logic [DATAW-1:0] r_mem [NBANKS][ROWS];
  logic [PTRW-1:0]  r_ptr [NBANKS];
  logic [DATAW-1:0] r_rdata [NCORES];
  logic [ADDRW-1:0] r_resvAddr [NCORES];
  logic [NCORES-1:0] r_resvValid;

  function automatic int wrapIdx(input logic [PTRW-1:0] p, input int k);
    return (int'(p) + k) % NCORES;
  endfunction

  for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
    assign w_addr[gi]  = addr_packed_i[ADDRW*gi +: ADDRW];
    assign w_wdata[gi] = wdata_packed_i[DATAW*gi +: DATAW];
    assign w_wstrb[gi] = wstrb_packed_i[STRBW*gi +: STRBW];
    assign w_row[gi]   = w_addr[gi][ADDRW-1:LOGNB];
    if (LOGNB > 0) begin : g_sel
      assign w_bsel[gi] = w_addr[gi][BSELW-1:0];
    end else begin : g_nosel
      assign w_bsel[gi] = '0;
    end
    assign w_scOk[gi] = r_resvValid[gi] && (r_resvAddr[gi] == w_addr[gi]);
    assign rdata_packed_o[DATAW*gi +: DATAW] = r_rdata[gi];
  end

  // A request with both re and we set counts as a write, so it is never an LR
  assign w_req = re_packed_i | we_packed_i;
  assign w_lr  = re_packed_i & ~we_packed_i & is_lr_packed_i;
  assign w_sc  = we_packed_i & is_sc_packed_i;
  assign stall_packed_o = rst_ni ? (w_req & ~w_grant) : '0;

  // Round-robin search per bank, starting at that bank's pointer; no grants during reset
  always_comb begin
    w_bankGnt = '0;
    w_grant   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      w_bankCore[b] = '0;
      for (int k = 0; k < NCORES; k++) begin
        if (!w_bankGnt[b] && w_req[wrapIdx(r_ptr[b], k)] &&
            (w_bsel[wrapIdx(r_ptr[b], k)] == BSELW'(b))) begin
          w_bankGnt[b]  = 1'b1;
          w_bankCore[b] = PTRW'(wrapIdx(r_ptr[b], k));
        end
      end
    end
    if (!rst_ni) begin
      w_bankGnt = '0;
    end
    for (int i = 0; i < NCORES; i++) begin
      w_grant[i] = w_bankGnt[w_bsel[i]] && (w_bankCore[w_bsel[i]] == PTRW'(i));
    end
  end

  // Route the granted core's fields to its bank; a failing SC performs no write
  always_comb begin
    w_bankWrite = '0;
    for (int b = 0; b < NBANKS; b++) begin
      w_bankRow[b]   = w_row[w_bankCore[b]];
      w_bankAddr[b]  = w_addr[w_bankCore[b]];
      w_bankWdata[b] = w_wdata[w_bankCore[b]];
      w_bankWstrb[b] = w_wstrb[w_bankCore[b]];
      w_bankRdata[b] = r_mem[b][w_bankRow[b]];
      w_bankWrite[b] = w_bankGnt[b] && we_packed_i[w_bankCore[b]] &&
                       (!is_sc_packed_i[w_bankCore[b]] || w_scOk[w_bankCore[b]]);
    end
  end

  // Bank storage with byte strobes; contents survive reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (w_bankWrite[b]) begin
        for (int by = 0; by < STRBW; by++) begin
          if (w_bankWstrb[b][by]) begin
            r_mem[b][w_bankRow[b]][8*by +: 8] <= w_bankWdata[b][8*by +: 8];
          end
        end
      end
    end
  end

  // Response register per core, updated only when that core is granted
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCORES; i++) begin
      if (!rst_ni) begin
        r_rdata[i] <= '0;
      end else if (w_grant[i]) begin
        if (we_packed_i[i]) begin
          r_rdata[i] <= (is_sc_packed_i[i] && !w_scOk[i]) ? DATAW'(1) : '0;
        end else begin
          r_rdata[i] <= w_bankRdata[w_bsel[i]];
        end
      end
    end
  end

  // Reservations: performed writes kill matching entries first, then the core's own LR/SC updates it
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NCORES; j++) begin
      if (!rst_ni) begin
        r_resvValid[j] <= 1'b0;
        r_resvAddr[j]  <= '0;
      end else begin
        for (int b = 0; b < NBANKS; b++) begin
          if (w_bankWrite[b] && (r_resvAddr[j] == w_bankAddr[b])) begin
            r_resvValid[j] <= 1'b0;
          end
        end
        if (w_grant[j] && w_lr[j]) begin
          r_resvValid[j] <= 1'b1;
          r_resvAddr[j]  <= w_addr[j];
        end else if (w_grant[j] && w_sc[j]) begin
          r_resvValid[j] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointers advance past the core each bank just served
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (!rst_ni) begin
        r_ptr[b] <= '0;
      end else if (w_bankGnt[b]) begin
        r_ptr[b] <= PTRW'((int'(w_bankCore[b]) + 1) % NCORES);
      end
    end
  end

endmodule

// File: tb/tb_banked_dmem_ctrl.sv
// Directed bench for banked_dmem_ctrl (4 cores, 2 banks).
// Stall is checked mid-cycle; expected responses are queued when a step is driven
// and popped after the clock edge that should produce them.
module tb_banked_dmem_ctrl;

  logic clk = 1'b0;
  logic rst_ni;
  logic [3:0] re, we, lr, sc;
  logic [11:0] addr [4];
  logic [31:0] wdata [4];
  logic [3:0]  wstrb [4];
  logic [47:0]  addrPacked;
  logic [127:0] wdataPacked;
  logic [15:0]  wstrbPacked;
  logic [127:0] rdataPacked;
  logic [3:0]   stallPacked;

  typedef struct {
    int          core;
    logic [31:0] val;
    string       tag;
  } resp_t;

  resp_t sbQ[$];
  int checks = 0;
  int failures = 0;

  banked_dmem_ctrl #(.NCORES(4), .NBANKS(2), .ADDRW(12), .DATAW(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .re_packed_i    (re),
    .we_packed_i    (we),
    .addr_packed_i  (addrPacked),
    .wdata_packed_i (wdataPacked),
    .wstrb_packed_i (wstrbPacked),
    .is_lr_packed_i (lr),
    .is_sc_packed_i (sc),
    .rdata_packed_o (rdataPacked),
    .stall_packed_o (stallPacked)
  );

  always #5 clk = ~clk;

  // Pack the per-core request fields onto the DUT buses
  always_comb begin
    addrPacked  = '0;
    wdataPacked = '0;
    wstrbPacked = '0;
    for (int i = 0; i < 4; i++) begin
      addrPacked[12*i +: 12] = addr[i];
      wdataPacked[32*i +: 32] = wdata[i];
      wstrbPacked[4*i +: 4]   = wstrb[i];
    end
  end

  task automatic idleAll();
    re = '0; we = '0; lr = '0; sc = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
  endtask

  task automatic setCore(input int c, input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic l, input logic scv);
    re[c] = r; we[c] = w; addr[c] = a; wdata[c] = d; wstrb[c] = s; lr[c] = l; sc[c] = scv;
  endtask

  task automatic doRead(input int c, input logic [11:0] a);
    setCore(c, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic doWrite(input int c, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    setCore(c, 1'b0, 1'b1, a, d, s, 1'b0, 1'b0);
  endtask

  task automatic doLr(input int c, input logic [11:0] a);
    setCore(c, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic doSc(input int c, input logic [11:0] a, input logic [31:0] d);
    setCore(c, 1'b0, 1'b1, a, d, 4'hF, 1'b0, 1'b1);
  endtask

  task automatic expectResp(input int c, input logic [31:0] v, input string tag);
    resp_t e;
    e.core = c; e.val = v; e.tag = tag;
    sbQ.push_back(e);
  endtask

  // Pop every response queued for this cycle and compare it with the core's rdata
  task automatic checkOutput();
    resp_t e;
    logic [31:0] obs;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      obs = rdataPacked[32*e.core +: 32];
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s core%0d rdata observed=%h expected=%h", e.tag, e.core, obs, e.val);
      end
    end
  endtask

  // Run one cycle: check stall mid-cycle, clock, then check the queued responses
  task automatic applyStimulus(input logic [3:0] expStall, input string tag);
    @(negedge clk);
    checks++;
    assert (stallPacked === expStall) else begin
      failures++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stallPacked, expStall);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_ni = 1'b0;
    idleAll();

    $display("[TB] reset with requests pending");
    doRead(0, 12'h000); doRead(1, 12'h002);
    for (int c = 0; c < 4; c++) expectResp(c, 32'h0, "rstRdata");
    applyStimulus(4'b0000, "rstStall");
    rst_ni = 1'b1;

    $display("[TB] write then read back");
    idleAll(); doWrite(0, 12'h010, 32'hDEADBEEF, 4'hF);
    expectResp(0, 32'h0, "wrAck");
    applyStimulus(4'b0000, "wrStall");
    idleAll(); doRead(0, 12'h010);
    expectResp(0, 32'hDEADBEEF, "rdBack");
    applyStimulus(4'b0000, "rdStall");

    $display("[TB] byte strobes and re+we as write");
    idleAll(); doWrite(0, 12'h020, 32'h11223344, 4'hF);
    expectResp(0, 32'h0, "strbFull");
    applyStimulus(4'b0000, "strbFullStall");
    idleAll(); doWrite(0, 12'h020, 32'h0000AA00, 4'b0010);
    expectResp(0, 32'h0, "strbPart");
    applyStimulus(4'b0000, "strbPartStall");
    idleAll(); doRead(0, 12'h020);
    expectResp(0, 32'h1122AA44, "strbMerge");
    applyStimulus(4'b0000, "strbReadStall");
    idleAll(); setCore(0, 1'b1, 1'b1, 12'h022, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
    expectResp(0, 32'h0, "reWeAck");
    applyStimulus(4'b0000, "reWeStall");
    idleAll(); doRead(0, 12'h022);
    expectResp(0, 32'h0BADF00D, "reWeRead");
    applyStimulus(4'b0000, "reWeReadStall");

    $display("[TB] preload and bank conflict");
    idleAll(); doWrite(0, 12'h000, 32'hA0, 4'hF);
    expectResp(0, 32'h0, "pre0");
    applyStimulus(4'b0000, "pre0Stall");
    idleAll(); doWrite(1, 12'h002, 32'hA2, 4'hF); doWrite(3, 12'h001, 32'hB1, 4'hF);
    expectResp(1, 32'h0, "pre1"); expectResp(3, 32'h0, "pre3");
    applyStimulus(4'b0000, "preParallelStall");
    idleAll(); doWrite(2, 12'h004, 32'hA4, 4'hF);
    expectResp(2, 32'h0, "pre2");
    applyStimulus(4'b0000, "pre2Stall");
    idleAll();
    doRead(0, 12'h000); doRead(1, 12'h002); doRead(2, 12'h004); doRead(3, 12'h001);
    expectResp(0, 32'hA0, "conf0"); expectResp(3, 32'hB1, "conf3");
    expectResp(1, 32'h0, "conf1Hold"); expectResp(2, 32'h0, "conf2Hold");
    applyStimulus(4'b0110, "confStallC0");
    idleAll(); doRead(1, 12'h002); doRead(2, 12'h004);
    expectResp(1, 32'hA2, "conf1"); expectResp(0, 32'hA0, "conf0Hold");
    applyStimulus(4'b0100, "confStallC1");
    idleAll(); doRead(2, 12'h004);
    expectResp(2, 32'hA4, "conf2");
    applyStimulus(4'b0000, "confStallC2");
    idleAll(); doRead(0, 12'h000); doRead(3, 12'h010);
    expectResp(3, 32'hDEADBEEF, "ptrAt3");
    applyStimulus(4'b0001, "ptrAt3Stall");
    idleAll(); doRead(0, 12'h000);
    expectResp(0, 32'hA0, "ptrWrap");
    applyStimulus(4'b0000, "ptrWrapStall");

    $display("[TB] LR/SC with intervening write");
    idleAll(); doWrite(3, 12'h040, 32'h12345678, 4'hF);
    expectResp(3, 32'h0, "lrPre");
    applyStimulus(4'b0000, "lrPreStall");
    idleAll(); doLr(0, 12'h040);
    expectResp(0, 32'h12345678, "lrData");
    applyStimulus(4'b0000, "lrStall");
    idleAll(); doWrite(1, 12'h040, 32'h55, 4'hF);
    expectResp(1, 32'h0, "kill");
    applyStimulus(4'b0000, "killStall");
    idleAll(); doSc(0, 12'h040, 32'h99);
    expectResp(0, 32'h1, "scFailKilled");
    applyStimulus(4'b0000, "scFailStall");
    idleAll(); doRead(0, 12'h040);
    expectResp(0, 32'h55, "scFailMem");
    applyStimulus(4'b0000, "scFailMemStall");
    idleAll(); doLr(0, 12'h040);
    expectResp(0, 32'h55, "lr2Data");
    applyStimulus(4'b0000, "lr2Stall");
    idleAll(); doSc(0, 12'h040, 32'h99);
    expectResp(0, 32'h0, "scOk");
    applyStimulus(4'b0000, "scOkStall");
    idleAll(); doRead(0, 12'h040);
    expectResp(0, 32'h99, "scOkMem");
    applyStimulus(4'b0000, "scOkMemStall");

    $display("[TB] SC race");
    idleAll(); doWrite(0, 12'h030, 32'h30303030, 4'hF);
    expectResp(0, 32'h0, "racePre");
    applyStimulus(4'b0000, "racePreStall");
    idleAll(); doLr(0, 12'h030); doLr(1, 12'h030);
    expectResp(1, 32'h30303030, "raceLr1"); expectResp(0, 32'h0, "raceLr0Hold");
    applyStimulus(4'b0001, "raceLrStall");
    idleAll(); doLr(0, 12'h030);
    expectResp(0, 32'h30303030, "raceLr0");
    applyStimulus(4'b0000, "raceLr0Stall");
    idleAll(); doSc(0, 12'h030, 32'hC0C0C0C0); doSc(1, 12'h030, 32'hC1C1C1C1);
    expectResp(1, 32'h0, "raceSc1Win");
    applyStimulus(4'b0001, "raceScStall");
    idleAll(); doSc(0, 12'h030, 32'hC0C0C0C0);
    expectResp(0, 32'h1, "raceSc0Lose");
    applyStimulus(4'b0000, "raceSc0Stall");
    idleAll(); doRead(2, 12'h030);
    expectResp(2, 32'hC1C1C1C1, "raceMem");
    applyStimulus(4'b0000, "raceMemStall");

    $display("[TB] reset mid-operation");
    idleAll(); doWrite(2, 12'h050, 32'h50505050, 4'hF);
    expectResp(2, 32'h0, "rstPre");
    applyStimulus(4'b0000, "rstPreStall");
    idleAll(); doLr(2, 12'h050);
    expectResp(2, 32'h50505050, "rstLr");
    applyStimulus(4'b0000, "rstLrStall");
    rst_ni = 1'b0;
    idleAll(); doRead(0, 12'h050); doRead(1, 12'h052);
    for (int c = 0; c < 4; c++) expectResp(c, 32'h0, "midRstRdata");
    applyStimulus(4'b0000, "midRstStall");
    rst_ni = 1'b1;
    idleAll(); doSc(2, 12'h050, 32'hBAD0BAD0); doRead(3, 12'h010);
    expectResp(2, 32'h1, "rstScFail"); expectResp(3, 32'h0, "rstHold3");
    expectResp(0, 32'h0, "rstHold0"); expectResp(1, 32'h0, "rstHold1");
    applyStimulus(4'b1000, "rstPtrStall");
    idleAll(); doRead(3, 12'h010);
    expectResp(3, 32'hDEADBEEF, "rstCore3");
    applyStimulus(4'b0000, "rstCore3Stall");
    idleAll(); doRead(2, 12'h050);
    expectResp(2, 32'h50505050, "rstNoWrite");
    applyStimulus(4'b0000, "rstNoWriteStall");

    idleAll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
